// File: rtl/dsbpm_rate_strobe_gen_if.sv
// Sample/marker/config bus and strobe/status outputs of the rate strobe generator.
// Latency: none, wires only. Optional mismatchCount field under STROBE_GEN_MISMATCH_COUNT_EN.
// Backpressure: none; samples are qualified by sampleValid only.
interface dsbpm_rate_strobe_gen_if #(
  parameter int SPT_WIDTH = 10,
  parameter int TPT_WIDTH = 8,
  parameter int FA_WIDTH  = 12,
  parameter int SA_WIDTH  = 16
);
  logic                 sampleValid;
  logic                 evrMarker;
  logic [1:0]           resyncMode;
  logic                 cfgLoad;
  logic [SPT_WIDTH-1:0] cfgSamplesPerTurn;
  logic [TPT_WIDTH-1:0] cfgTurnsPerPt;
  logic [FA_WIDTH-1:0]  cfgFaDecimate;
  logic [SA_WIDTH-1:0]  cfgSaDecimate;
  logic                 cfgError;
  logic                 turnStrobe;
  logic                 ptStrobe;
  logic                 faStrobe;
  logic                 saStrobe;
  logic [SPT_WIDTH-1:0] samplePhase;
  logic [TPT_WIDTH-1:0] ptTurn;
  logic [1:0]           state;
  logic                 locked;
  logic                 mismatch;
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
  logic [15:0]          mismatchCount;
`endif

  modport master (
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
    input  mismatchCount,
`endif
    output sampleValid, evrMarker, resyncMode, cfgLoad,
    output cfgSamplesPerTurn, cfgTurnsPerPt, cfgFaDecimate, cfgSaDecimate,
    input  cfgError, turnStrobe, ptStrobe, faStrobe, saStrobe,
    input  samplePhase, ptTurn, state, locked, mismatch
  );

  modport slave (
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
    output mismatchCount,
`endif
    input  sampleValid, evrMarker, resyncMode, cfgLoad,
    input  cfgSamplesPerTurn, cfgTurnsPerPt, cfgFaDecimate, cfgSaDecimate,
    output cfgError, turnStrobe, ptStrobe, faStrobe, saStrobe,
    output samplePhase, ptTurn, state, locked, mismatch
  );
endinterface

// File: rtl/dsbpm_rate_strobe_gen.sv
// Turn/PT/FA/SA strobe generator aligned to the EVR marker; STROBE_GEN_MISMATCH_COUNT_EN adds mismatchCount.
// Latency: strobes, status and cfgError are registered one cycle after the sample/marker/load.
// Backpressure: none; counting advances only on sampleValid, idle cycles hold all counters.
module dsbpm_rate_strobe_gen #(
  parameter int SAMPLES_PER_TURN = 81,
  parameter int TURNS_PER_PT     = 19,
  parameter int FA_DECIMATE      = 76,
  parameter int SA_DECIMATE      = 1000,
  parameter int SPT_WIDTH        = 10,
  parameter int TPT_WIDTH        = 8,
  parameter int FA_WIDTH         = 12,
  parameter int SA_WIDTH         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dsbpm_rate_strobe_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGNED = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [SPT_WIDTH-1:0] SPT_DEF = SPT_WIDTH'(SAMPLES_PER_TURN);
  localparam logic [TPT_WIDTH-1:0] TPT_DEF = TPT_WIDTH'(TURNS_PER_PT);
  localparam logic [FA_WIDTH-1:0]  FA_DEF  = FA_WIDTH'(FA_DECIMATE);
  localparam logic [SA_WIDTH-1:0]  SA_DEF  = SA_WIDTH'(SA_DECIMATE);

  state_t               st;
  logic                 locked_q, mismatch_q, cfg_err_q;
  logic                 turn_stb, pt_stb, fa_stb, sa_stb;
  logic                 pending;
  logic [SPT_WIDTH-1:0] spt, spt_sh, phase;
  logic [TPT_WIDTH-1:0] tpt, tpt_sh, turn;
  logic [FA_WIDTH-1:0]  fa, fa_sh, fa_cnt;
  logic [SA_WIDTH-1:0]  sa, sa_sh, sa_cnt;

  logic                 first_mk, chk_mk, on_bound, apply, mis, zero, adv, cfg_bad;
  logic                 turn_wrap, fa_wrap;
  logic [SPT_WIDTH-1:0] spt_use, ph_e, ph_n;
  logic [TPT_WIDTH-1:0] tpt_use, turn_e, turn_n;
  logic [FA_WIDTH-1:0]  fa_use, fa_e, fa_n;
  logic [SA_WIDTH-1:0]  sa_use, sa_e, sa_n;

  always_comb begin
    first_mk = bus.evrMarker && (st == IDLE);
    // Mode 0 ignores every marker once running.
    chk_mk   = bus.evrMarker && (st != IDLE) && (bus.resyncMode != 2'd0);
    on_bound = (phase == '0) && (turn == '0);
    apply    = first_mk || (chk_mk && on_bound && pending);
    mis      = chk_mk && !on_bound;
    zero     = apply || (mis && (bus.resyncMode != 2'd2));
    adv      = bus.sampleValid && ((st != IDLE) || first_mk);

    spt_use = apply ? spt_sh : spt;
    tpt_use = apply ? tpt_sh : tpt;
    fa_use  = apply ? fa_sh  : fa;
    sa_use  = apply ? sa_sh  : sa;

    // Effective position of this cycle's sample after any realignment.
    ph_e   = zero ? '0 : phase;
    turn_e = zero ? '0 : turn;
    fa_e   = zero ? '0 : fa_cnt;
    sa_e   = zero ? '0 : sa_cnt;

    turn_wrap = (ph_e == spt_use - SPT_WIDTH'(1));
    fa_wrap   = (fa_e == fa_use - FA_WIDTH'(1));

    ph_n   = ph_e;
    turn_n = turn_e;
    fa_n   = fa_e;
    sa_n   = sa_e;
    if (adv) begin
      ph_n = turn_wrap ? '0 : ph_e + SPT_WIDTH'(1);
      if (turn_wrap) begin
        turn_n = (turn_e == tpt_use - TPT_WIDTH'(1)) ? '0 : turn_e + TPT_WIDTH'(1);
        fa_n   = fa_wrap ? '0 : fa_e + FA_WIDTH'(1);
        if (fa_wrap) begin
          sa_n = (sa_e == sa_use - SA_WIDTH'(1)) ? '0 : sa_e + SA_WIDTH'(1);
        end
      end
    end

    cfg_bad = (bus.cfgSamplesPerTurn < SPT_WIDTH'(2)) || (bus.cfgTurnsPerPt < TPT_WIDTH'(2)) ||
              (bus.cfgFaDecimate < FA_WIDTH'(2)) || (bus.cfgSaDecimate < SA_WIDTH'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      turn_stb   <= 1'b0;
      pt_stb     <= 1'b0;
      fa_stb     <= 1'b0;
      sa_stb     <= 1'b0;
      pending    <= 1'b0;
      phase      <= '0;
      turn       <= '0;
      fa_cnt     <= '0;
      sa_cnt     <= '0;
      spt        <= SPT_DEF;
      tpt        <= TPT_DEF;
      fa         <= FA_DEF;
      sa         <= SA_DEF;
      spt_sh     <= SPT_DEF;
      tpt_sh     <= TPT_DEF;
      fa_sh      <= FA_DEF;
      sa_sh      <= SA_DEF;
    end else begin
      phase      <= ph_n;
      turn       <= turn_n;
      fa_cnt     <= fa_n;
      sa_cnt     <= sa_n;
      turn_stb   <= adv && (ph_e == '0);
      pt_stb     <= adv && (ph_e == '0) && (turn_e == '0);
      fa_stb     <= adv && (ph_e == '0) && (fa_e == '0);
      sa_stb     <= adv && (ph_e == '0) && (fa_e == '0) && (sa_e == '0);
      mismatch_q <= mis;
      cfg_err_q  <= bus.cfgLoad && cfg_bad;

      if (first_mk) begin
        st       <= (bus.resyncMode == 2'd0) ? LOCKED : ALIGNED;
        locked_q <= (bus.resyncMode == 2'd0);
      end else if (chk_mk) begin
        // A config change forces a fresh alignment even on a good marker.
        st       <= (on_bound && !pending) ? LOCKED : ALIGNED;
        locked_q <= on_bound && !pending;
      end

      if (apply) begin
        spt     <= spt_sh;
        tpt     <= tpt_sh;
        fa      <= fa_sh;
        sa      <= sa_sh;
        pending <= 1'b0;
      end

      // A load coinciding with a marker stays pending; the marker used the old shadow.
      if (bus.cfgLoad && !cfg_bad) begin
        spt_sh <= bus.cfgSamplesPerTurn;
        tpt_sh <= bus.cfgTurnsPerPt;
        fa_sh  <= bus.cfgFaDecimate;
        sa_sh  <= bus.cfgSaDecimate;
        if ((st == IDLE) && !bus.evrMarker) begin
          spt     <= bus.cfgSamplesPerTurn;
          tpt     <= bus.cfgTurnsPerPt;
          fa      <= bus.cfgFaDecimate;
          sa      <= bus.cfgSaDecimate;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  assign bus.cfgError    = cfg_err_q;
  assign bus.turnStrobe  = turn_stb;
  assign bus.ptStrobe    = pt_stb;
  assign bus.faStrobe    = fa_stb;
  assign bus.saStrobe    = sa_stb;
  assign bus.samplePhase = phase;
  assign bus.ptTurn      = turn;
  assign bus.state       = st;
  assign bus.locked      = locked_q;
  assign bus.mismatch    = mismatch_q;

`ifdef STROBE_GEN_MISMATCH_COUNT_EN
  logic [15:0] mis_cnt;

  always_ff @(posedge clk) begin
    if (rst || first_mk) begin
      mis_cnt <= '0;
    end else if (mis && (mis_cnt != 16'hFFFF)) begin
      mis_cnt <= mis_cnt + 16'd1;
    end
  end

  assign bus.mismatchCount = mis_cnt;
`endif
endmodule

// File: tb/tb_dsbpm_rate_strobe_gen.sv
// Bench for dsbpm_rate_strobe_gen: directed marker/config scenarios against a sample-count model.
// The model tracks samples since the alignment origin and derives every output arithmetically.
module tb_dsbpm_rate_strobe_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsbpm_rate_strobe_gen_if bus ();
  dsbpm_rate_strobe_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int     m_spt, m_tpt, m_fa, m_sa, s_spt, s_tpt, s_fa, s_sa;
  int     m_state, m_mode, m_cnt, e_ph, e_tn;
  longint n;
  bit     pend, counting, match, apply, zero, chk_en = 1'b0;
  bit     e_turn, e_pt, e_fa, e_sa, e_mis, e_err;

  always @(posedge clk) begin
    if (rst) begin
      m_spt = 81; m_tpt = 19; m_fa = 76; m_sa = 1000;
      s_spt = 81; s_tpt = 19; s_fa = 76; s_sa = 1000;
      pend = 0; n = 0; m_state = 0; m_cnt = 0;
      e_turn = 0; e_pt = 0; e_fa = 0; e_sa = 0; e_mis = 0; e_err = 0;
      chk_en = 1;
    end else begin
      m_mode   = int'(bus.resyncMode);
      counting = (m_state != 0) || bus.evrMarker;
      match    = ((n % m_spt) == 0) && (((n / m_spt) % m_tpt) == 0);
      apply = 0; zero = 0; e_mis = 0;
      if (bus.evrMarker && m_state == 0) begin
        apply = 1; zero = 1; m_cnt = 0;
        m_state = (m_mode == 0) ? 2 : 1;
      end else if (bus.evrMarker && m_mode != 0) begin
        if (match) begin
          if (pend) begin apply = 1; zero = 1; m_state = 1; end
          else m_state = 2;
        end else begin
          e_mis = 1;
          if (m_cnt < 65535) m_cnt++;
          if (m_mode != 2) zero = 1;
          m_state = 1;
        end
      end
      if (apply) begin
        m_spt = s_spt; m_tpt = s_tpt; m_fa = s_fa; m_sa = s_sa; pend = 0;
      end
      if (zero) n = 0;
      e_turn = 0; e_pt = 0; e_fa = 0; e_sa = 0;
      if (counting && bus.sampleValid) begin
        e_turn = (n % m_spt) == 0;
        e_pt   = (n % (m_spt * m_tpt)) == 0;
        e_fa   = (n % (m_spt * m_fa)) == 0;
        e_sa   = (n % (longint'(m_spt) * m_fa * m_sa)) == 0;
        n++;
      end
      e_err = 0;
      if (bus.cfgLoad) begin
        if (bus.cfgSamplesPerTurn < 2 || bus.cfgTurnsPerPt < 2 ||
            bus.cfgFaDecimate < 2 || bus.cfgSaDecimate < 2) begin
          e_err = 1;
        end else begin
          s_spt = int'(bus.cfgSamplesPerTurn); s_tpt = int'(bus.cfgTurnsPerPt);
          s_fa  = int'(bus.cfgFaDecimate);     s_sa  = int'(bus.cfgSaDecimate);
          if (!counting) begin
            m_spt = s_spt; m_tpt = s_tpt; m_fa = s_fa; m_sa = s_sa; pend = 0;
          end else begin
            pend = 1;
          end
        end
      end
    end
    e_ph = int'(n % m_spt);
    e_tn = int'((n / m_spt) % m_tpt);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("turnStrobe", bus.turnStrobe, e_turn);
      check("ptStrobe", bus.ptStrobe, e_pt);
      check("faStrobe", bus.faStrobe, e_fa);
      check("saStrobe", bus.saStrobe, e_sa);
      check("samplePhase", bus.samplePhase, e_ph);
      check("ptTurn", bus.ptTurn, e_tn);
      check("state", bus.state, m_state);
      check("locked", bus.locked, m_state == 2);
      check("mismatch", bus.mismatch, e_mis);
      check("cfgError", bus.cfgError, e_err);
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
      check("mismatchCount", bus.mismatchCount, m_cnt);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  int c_turn, c_pt, c_fa, c_sa, t_first, t_gap, p_first, p_gap;
  int mk_state, mk_phase;
  bit mk_mis, mk_locked, mk_all, mk_turn;

  task automatic run(input int cycles, input int mk, input int gap);
    int s = -1;
    c_turn = 0; c_pt = 0; c_fa = 0; c_sa = 0;
    t_first = -1; t_gap = -1; p_first = -1; p_gap = -1;
    for (int k = 0; k < cycles; k++) begin
      bus.sampleValid = ((k % gap) == 0);
      bus.evrMarker   = (k == mk);
      if ((k % gap) == 0) s++;
      @(negedge clk);
      bus.evrMarker = 1'b0;
      c_turn += int'(bus.turnStrobe);
      c_pt   += int'(bus.ptStrobe);
      c_fa   += int'(bus.faStrobe);
      c_sa   += int'(bus.saStrobe);
      if (bus.turnStrobe) begin
        if (t_first < 0) t_first = s;
        else if (t_gap < 0) t_gap = s - t_first;
      end
      if (bus.ptStrobe) begin
        if (p_first < 0) p_first = s;
        else if (p_gap < 0) p_gap = s - p_first;
      end
      if (k == mk) begin
        mk_mis    = bus.mismatch;
        mk_state  = int'(bus.state);
        mk_locked = bus.locked;
        mk_turn   = bus.turnStrobe;
        mk_phase  = int'(bus.samplePhase);
        mk_all    = bus.turnStrobe && bus.ptStrobe && bus.faStrobe && bus.saStrobe;
      end
    end
  endtask

  task automatic load_cfg(input int a, input int b, input int c, input int d);
    bus.cfgSamplesPerTurn = a[9:0];
    bus.cfgTurnsPerPt     = b[7:0];
    bus.cfgFaDecimate     = c[11:0];
    bus.cfgSaDecimate     = d[15:0];
    bus.cfgLoad     = 1'b1;
    bus.sampleValid = 1'b1;
    bus.evrMarker   = 1'b0;
    @(negedge clk);
    bus.cfgLoad = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.sampleValid = 1'b0; bus.evrMarker = 1'b0; bus.resyncMode = 2'd1; bus.cfgLoad = 1'b0;
    bus.cfgSamplesPerTurn = 10'd81; bus.cfgTurnsPerPt = 8'd19;
    bus.cfgFaDecimate = 12'd76; bus.cfgSaDecimate = 16'd1000;
    repeat (2) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_turnStrobe", bus.turnStrobe, 0);
    check("rst_phase", bus.samplePhase, 0);
    rst = 1'b0;

    // 4/3/2/2 in IDLE applies at once; no counting until the first marker.
    load_cfg(4, 3, 2, 2);
    check("cfg_ok_err", bus.cfgError, 0);
    run(3, -1, 1);
    check("idle_no_strobe", c_turn, 0);

    run(12, 0, 1);
    check("first_all_strobes", mk_all, 1);
    check("first_phase", mk_phase, 1);
    check("first_state", mk_state, 1);
    check("cnt_turn_12", c_turn, 3);
    check("cnt_pt_12", c_pt, 1);
    check("cnt_fa_12", c_fa, 2);
    check("cnt_sa_12", c_sa, 1);

    run(12, 0, 1);
    check("second_locked", mk_locked, 1);
    check("second_no_mis", mk_mis, 0);

    // Mode 1: off-boundary marker resyncs.
    run(17, 5, 1);
    check("m1_mismatch", mk_mis, 1);
    check("m1_state", mk_state, 1);
    check("m1_all_strobes", mk_all, 1);
    run(12, 0, 1);
    check("m1_relock", mk_locked, 1);

    // Mode 2: off-boundary marker only reports.
    bus.resyncMode = 2'd2;
    run(17, 5, 1);
    check("m2_mismatch", mk_mis, 1);
    check("m2_state", mk_state, 1);
    check("m2_turn_kept", mk_turn, 0);
    check("m2_phase_kept", mk_phase, 2);
    run(8, 7, 1);
    check("m2_relock", mk_locked, 1);
    bus.resyncMode = 2'd1;

    load_cfg(4, 1, 2, 2);
    check("bad_cfg_err", bus.cfgError, 1);
    run(12, -1, 1);
    check("bad_cfg_pt", c_pt, 1);
    check("bad_cfg_turn", c_turn, 3);

    load_cfg(5, 2, 2, 2);
    check("good_cfg_err", bus.cfgError, 0);
    check("good_cfg_still_locked", bus.state, 2);
    run(10, 9, 1);
    check("apply_state", mk_state, 1);
    check("apply_all", mk_all, 1);
    check("apply_phase", mk_phase, 1);
    run(20, -1, 1);
    check("new_pt_count", c_pt, 2);
    check("new_turn_count", c_turn, 4);

    // Defaults with one valid sample in three.
    do_reset();
    run(4620, 0, 3);
    check("gap_turn_samples", t_gap, 81);
    check("gap_pt_samples", p_gap, 1539);

    do_reset();
    load_cfg(4, 3, 2, 2);
    run(12, 0, 1);
    for (int r = 0; r < 3; r++) run(17, 5, 1);
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
    check("mis_count_3", bus.mismatchCount, 3);
`endif
    // Marker coincident with reset is dropped.
    rst = 1'b1; bus.evrMarker = 1'b1; bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.evrMarker = 1'b0;
    check("rst_mid_state", bus.state, 0);
    check("rst_mid_strobe", bus.turnStrobe, 0);
`ifdef STROBE_GEN_MISMATCH_COUNT_EN
    check("rst_mid_count", bus.mismatchCount, 0);
`endif
    rst = 1'b0;
    run(4, -1, 1);
    check("post_rst_idle", c_turn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dsbpm_rate_strobe_gen.md
# dsbpm_rate_strobe_gen

Runtime-configurable turn / pilot-tone / FA / SA strobe generator for the DSBPM signal chain. It counts accepted ADC samples into turns, pilot-tone (PT) cycles, fast-acquisition (FA) and slow-acquisition (SA) periods. It aligns to the EVR heartbeat marker and reports lock state. It replaces the fixed compile-time SITE_SAMPLES_PER_TURN / SITE_TURNS_PER_PT / SITE_CIC_*_DECIMATE constants with parameter defaults that firmware can override per site. It sits in the ADC clock domain, ahead of the LO tables, CIC decimators and acquisition triggers.

## Interface
- SAMPLES_PER_TURN, 81: default samples per turn.
- TURNS_PER_PT, 19: default turns per PT cycle.
- FA_DECIMATE, 76: default turns per FA strobe.
- SA_DECIMATE, 1000: default FA strobes per SA strobe.
- SPT_WIDTH, 10 / TPT_WIDTH, 8 / FA_WIDTH, 12 / SA_WIDTH, 16: counter and config field widths.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  ADC-domain clock.
- rst  in  1  synchronous, active-high reset.
- sampleValid  in  1  one sample accepted per high cycle.
- evrMarker  in  1  single-cycle heartbeat, nominally on a PT-cycle boundary.
- resyncMode  in  2  0 = free-run, 1 = resync on mismatch, 2 = check-only, 3 = same as 1.
- cfgLoad  in  1  latch the four cfg fields into the shadow registers.
- cfgSamplesPerTurn / cfgTurnsPerPt / cfgFaDecimate / cfgSaDecimate  in  SPT/TPT/FA/SA_WIDTH  new ratios.
- cfgError  out  1  pulse: cfgLoad rejected.
- turnStrobe, ptStrobe, faStrobe, saStrobe  out  1  single-cycle strobes.
- samplePhase  out  SPT_WIDTH  phase of the next sample within its turn.
- ptTurn  out  TPT_WIDTH  turn index of the next sample within the PT cycle.
- state  out  2  0 = IDLE, 1 = ALIGNED, 2 = LOCKED.
- locked  out  1  state == LOCKED.
- mismatch  out  1  pulse: marker arrived off a PT boundary.

## Operation
- Reset values:
  - every output is 0; state is IDLE.
  - active and shadow ratios take the parameter defaults; no config is pending.
- Counting only advances on sampleValid.
  - samplePhase wraps at spt-1.
  - ptTurn advances on a samplePhase wrap and wraps at tpt-1.
  - The FA counter counts turns modulo fa; the SA counter counts FA wraps modulo sa.
- Strobes are registered and derive from the accepted sample with phase 0:
  - turnStrobe on every turn;
  - ptStrobe also requires ptTurn 0;
  - faStrobe also requires FA count 0;
  - saStrobe also requires FA and SA counts 0.
- IDLE: no counting, no strobes.
- First marker (any mode): apply pending config, zero all counters, treat that cycle's sample as phase 0, then go to ALIGNED (modes 1/2/3) or LOCKED (mode 0).
- Boundary check: a marker "matches" when (samplePhase, ptTurn) == (0,0) in the marker cycle, i.e. the sample accepted in that cycle, or the next sample if sampleValid is low, is phase 0 of turn 0.
- Matching marker:
  - ALIGNED → LOCKED.
  - If config is pending, apply it and zero all counters; LOCKED → ALIGNED.
- Non-matching marker:
  - mismatch pulses.
  - Mode 1/3: zero all counters as for the first marker; state → ALIGNED.
  - Mode 2: counters untouched; LOCKED → ALIGNED.
  - Mode 0: markers after the first are ignored, with no check and no mismatch.
- Config load:
  - cfgLoad with any field < 2 → cfgError, shadow unchanged.
  - Otherwise the shadow updates and config becomes pending. In IDLE it applies immediately.
  - A second cfgLoad before application overwrites the shadow.
- Simultaneous cfgLoad and marker: the marker uses the previous shadow; the new load stays pending.
- Simultaneous marker and rst: rst wins.
- rst mid-operation discards any pending config.

## Timing
- Marker-to-strobe latency: a marker with sampleValid applied in cycle n gives turnStrobe / ptStrobe / faStrobe / saStrobe all high in n+1. samplePhase reads 1 in n+1.
- Steady state: turnStrobe period is spt valid samples. ptStrobe period is spt·tpt samples. faStrobe period is spt·fa samples. saStrobe period is spt·fa·sa samples.
- mismatch, cfgError and state changes are registered, appearing in cycle n+1.
- Changing resyncMode takes effect from the next marker.

## Configuration
- STROBE_GEN_MISMATCH_COUNT_EN defined:
  - adds output mismatchCount (16 bits).
  - it increments on each mismatch pulse and saturates at 0xFFFF.
  - it clears on rst and on the first-marker application.
- Macro undefined: the port is absent and there is no counter logic.

## Test plan
- Reset, cfg 4/3/2/2, marker with sampleValid held high:
  - turnStrobe every 4 cycles; ptStrobe every 12; faStrobe every 8; saStrobe every 16.
  - state sequence IDLE→ALIGNED.
- Same config, second marker exactly 12 cycles later → locked=1, no mismatch.
- Mode 1, marker 5 cycles off boundary → mismatch pulse, ALIGNED, all strobes the next cycle, re-lock on the following aligned marker. Mode 2 with the same stimulus → mismatch, strobe phase unchanged.
- cfgLoad with cfgTurnsPerPt=1 → cfgError, strobe periods unchanged. Valid cfg 5/2/2/2 while LOCKED → applied at the next matching marker, ptStrobe period becomes 10, state ALIGNED.
- Gapped sampleValid (1 of 3 cycles) with defaults → exactly 81 valid samples between turnStrobes, 1539 between ptStrobes.
- With the macro defined, three off-boundary markers in mode 1 → mismatchCount=3. rst mid-count → 0, IDLE, no strobes.
